// File: rtl/ifetch_rsp.sv
// Instruction-memory responder: captures a fetch PC, reads the internal RAM
// after WAIT wait states and returns the word over a valid/ready handshake.
module ifetch_rsp #(
    parameter int          AW   = 12,
    parameter logic [31:0] BASE = 32'h80000000,
    parameter int          WAIT = 0,
    parameter logic [31:0] NOP  = 32'h00000013
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_val,
    output logic          req_rdy,
    input  logic [31:0]   req_pc,
    output logic          rsp_val,
    input  logic          rsp_rdy,
    output logic [31:0]   rsp_in,
    output logic          rsp_err,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAITS = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [1:0] WAIT_LD = (WAIT > 0) ? 2'(WAIT - 1) : 2'd0;

    logic [31:0]   mem [2**AW];

    logic [1:0]    state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          err_q, err_d;
    logic [31:0]   rsp_in_q, rsp_in_d;
    logic          rsp_err_q, rsp_err_d;

    logic [31:0]   off;
    logic          dec_err, acc, load, ld_err;
    logic [AW-1:0] dec_idx, ld_idx;

    // BASE is word-aligned, so off[1:0] equals req_pc[1:0].
    always_comb begin
        off     = req_pc - BASE;
        dec_idx = off[AW+1:2];
        dec_err = (off[1:0] != 2'b0) || (req_pc < BASE) || (off[31:AW+2] != '0);
    end

    assign req_rdy = !rst && ((state_q == S_IDLE) ||
                              (state_q == S_RESP && rsp_rdy && WAIT == 0));
    assign acc     = req_val && req_rdy;
    assign rsp_val = (state_q == S_RESP);
    assign rsp_in  = rsp_in_q;
    assign rsp_err = rsp_err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        err_d     = err_q;
        rsp_in_d  = rsp_in_q;
        rsp_err_d = rsp_err_q;
        load      = 1'b0;
        ld_idx    = dec_idx;
        ld_err    = dec_err;
        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    if (WAIT == 0) begin
                        state_d = S_RESP;
                        load    = 1'b1;
                    end else begin
                        state_d = S_WAITS;
                        cnt_d   = WAIT_LD;
                        idx_d   = dec_idx;
                        err_d   = dec_err;
                    end
                end
            end
            S_WAITS: begin
                if (cnt_q == 2'd0) begin
                    state_d = S_RESP;
                    load    = 1'b1;
                    ld_idx  = idx_q;
                    ld_err  = err_q;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_RESP: begin
                if (rsp_rdy) begin
                    if (acc) load = 1'b1;
                    else     state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // mem is updated with <=, so this read sees pre-write data on a collision.
        if (load) begin
            rsp_in_d  = ld_err ? NOP : mem[ld_idx];
            rsp_err_d = ld_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 2'd0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            rsp_in_q  <= NOP;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            rsp_in_q  <= rsp_in_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem[wr_addr] <= wr_data;
    end

endmodule

// File: tb/tb_ifetch_rsp.sv
// Directed bench for ifetch_rsp: a WAIT=0 and a WAIT=2 instance share the
// clock, reset, write port and rsp_rdy; each has its own request valid.
module tb_ifetch_rsp;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req_pc;
    logic        rsp_rdy;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;

    logic        req_val0, req_rdy0, rsp_val0, rsp_err0;
    logic [31:0] rsp_in0;
    logic        req_val2, req_rdy2, rsp_val2, rsp_err2;
    logic [31:0] rsp_in2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ifetch_rsp #(.WAIT(0)) dut0 (
        .clk(clk), .rst(rst), .req_val(req_val0), .req_rdy(req_rdy0),
        .req_pc(req_pc), .rsp_val(rsp_val0), .rsp_rdy(rsp_rdy),
        .rsp_in(rsp_in0), .rsp_err(rsp_err0), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    ifetch_rsp #(.WAIT(2)) dut2 (
        .clk(clk), .rst(rst), .req_val(req_val2), .req_rdy(req_rdy2),
        .req_pc(req_pc), .rsp_val(rsp_val2), .rsp_rdy(rsp_rdy),
        .rsp_in(rsp_in2), .rsp_err(rsp_err2), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_pc = 32'h0; rsp_rdy = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        req_val0 = 1'b0; req_val2 = 1'b0;
        tick(); tick();
        chk("rst_rdy_low", 32'(req_rdy0), 32'd0);
        chk("rst_val", 32'(rsp_val0), 32'd0);
        chk("rst_in", rsp_in0, 32'h00000013);
        chk("rst_err", 32'(rsp_err0), 32'd0);
        rst = 1'b0;
        #1 chk("idle_rdy", 32'(req_rdy0), 32'd1);

        // program load
        wr_en = 1'b1;
        wr_addr = 12'd0; wr_data = 32'h00500093; tick();
        wr_addr = 12'd1; wr_data = 32'h00108113; tick();
        wr_addr = 12'd5; wr_data = 32'hAAAA5555; tick();
        wr_en = 1'b0;

        // back-to-back, WAIT=0
        rsp_rdy = 1'b1; req_val0 = 1'b1; req_pc = 32'h80000000;
        tick();
        chk("b2b_val1", 32'(rsp_val0), 32'd1);
        chk("b2b_in1", rsp_in0, 32'h00500093);
        chk("b2b_err1", 32'(rsp_err0), 32'd0);
        req_pc = 32'h80000004;
        #1 chk("b2b_rdy", 32'(req_rdy0), 32'd1);
        tick();
        chk("b2b_val2", 32'(rsp_val0), 32'd1);
        chk("b2b_in2", rsp_in0, 32'h00108113);
        req_val0 = 1'b0;
        tick();
        chk("b2b_drain", 32'(rsp_val0), 32'd0);

        // stall with a write to the fetched word
        req_val0 = 1'b1; req_pc = 32'h80000000; rsp_rdy = 1'b0;
        tick();
        wr_en = 1'b1; wr_addr = 12'd0; wr_data = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_rdy", 32'(req_rdy0), 32'd0);
            tick();
            chk("stall_val", 32'(rsp_val0), 32'd1);
            chk("stall_in", rsp_in0, 32'h00500093);
            wr_en = 1'b0;
        end
        rsp_rdy = 1'b1;
        #1 chk("unstall_rdy", 32'(req_rdy0), 32'd1);
        tick();
        chk("refetch_new", rsp_in0, 32'hFFFFFFFF);

        // error decode plus the last in-range word
        req_pc = 32'h80000002; tick();
        chk("err_mis", 32'(rsp_err0), 32'd1);
        chk("err_mis_in", rsp_in0, 32'h00000013);
        req_pc = 32'h7FFFFFFC; tick();
        chk("err_low", 32'(rsp_err0), 32'd1);
        chk("err_low_in", rsp_in0, 32'h00000013);
        req_pc = 32'h80004000; tick();
        chk("err_high", 32'(rsp_err0), 32'd1);
        chk("err_high_in", rsp_in0, 32'h00000013);
        req_pc = 32'h80003FFC; tick();
        chk("last_ok", 32'(rsp_err0), 32'd0);
        req_val0 = 1'b0; tick();

        // same-cycle write and read of idx 5
        req_val0 = 1'b1; req_pc = 32'h80000014;
        wr_en = 1'b1; wr_addr = 12'd5; wr_data = 32'h12345678;
        tick();
        wr_en = 1'b0;
        chk("rbw_old", rsp_in0, 32'hAAAA5555);
        tick();
        chk("rbw_new", rsp_in0, 32'h12345678);
        req_val0 = 1'b0; tick();

        // WAIT=2 latency
        req_val2 = 1'b1; req_pc = 32'h80000004;
        #1 chk("w2_rdy0", 32'(req_rdy2), 32'd1);
        tick();
        chk("w2_rdy1", 32'(req_rdy2), 32'd0);
        chk("w2_val1", 32'(rsp_val2), 32'd0);
        tick();
        chk("w2_rdy2", 32'(req_rdy2), 32'd0);
        chk("w2_val2", 32'(rsp_val2), 32'd0);
        tick();
        chk("w2_val3", 32'(rsp_val2), 32'd1);
        chk("w2_in3", rsp_in2, 32'h00108113);
        chk("w2_rdy3", 32'(req_rdy2), 32'd0);
        req_val2 = 1'b0;
        tick();
        chk("w2_drain", 32'(rsp_val2), 32'd0);

        // reset while in WAITS
        req_val2 = 1'b1; req_pc = 32'h80000000; tick();
        req_val2 = 1'b0; rst = 1'b1; tick();
        rst = 1'b0;
        chk("rw_val", 32'(rsp_val2), 32'd0);
        chk("rw_in", rsp_in2, 32'h00000013);
        #1 chk("rw_rdy", 32'(req_rdy2), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rw_nostale", 32'(rsp_val2), 32'd0);
        end

        // reset while in RESP with the consumer stalled
        rsp_rdy = 1'b0; req_val0 = 1'b1; req_pc = 32'h80000004; tick();
        chk("rr_val_pre", 32'(rsp_val0), 32'd1);
        rst = 1'b1; tick();
        rst = 1'b0; req_val0 = 1'b0;
        chk("rr_val", 32'(rsp_val0), 32'd0);
        chk("rr_in", rsp_in0, 32'h00000013);
        chk("rr_err", 32'(rsp_err0), 32'd0);
        #1 chk("rr_rdy", 32'(req_rdy0), 32'd1);
        tick();
        chk("rr_nostale", 32'(rsp_val0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_rsp.md
Name: ifetch_rsp

Overview:
Instruction-memory responder at the memory end of the fetch interface. It accepts a fetch PC from the fetch/read stage, looks up the word in an internal instruction RAM after a configurable number of wait states, and returns the instruction with a valid/ready handshake. Each response is held stable until it is consumed. A side write port loads the program image.

Parameters:
AW, 12, word-address width; RAM depth is 2**AW 32-bit words
BASE, 32'h80000000, byte address of RAM word 0; matches the core reset PC
WAIT, 0, extra wait-state cycles per fetch (legal 0..3)
NOP, 32'h00000013, instruction returned on error and after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
req_val  in  1  fetch request valid
req_rdy  out  1  responder can accept a request this cycle
req_pc  in  32  fetch byte address
rsp_val  out  1  response valid
rsp_rdy  in  1  consumer accepts the response
rsp_in  out  32  fetched instruction
rsp_err  out  1  fetch fault: misaligned or out-of-range
wr_en  in  1  program-load write strobe
wr_addr  in  AW  program-load word index
wr_data  in  32  program-load data

Behaviour:
- Reset is synchronous. In the cycle after rst is high: state=IDLE, rsp_val=0, rsp_in=NOP, rsp_err=0, wait counter=0. RAM contents are not reset.
- Request accept: a request is accepted when req_val && req_rdy at a clock edge. req_pc is captured at that edge.
- req_rdy = (state==IDLE) || (state==RESP && rsp_rdy && WAIT==0). req_rdy is 0 in WAITS. req_rdy is 0 while rst is high.
- Address decode: idx = (req_pc - BASE) >> 2.
  - Error if req_pc[1:0] != 0, if req_pc < BASE, or if (req_pc - BASE) >= 4*2**AW.
  - On error: rsp_in = NOP, rsp_err = 1, and the RAM data is ignored.
- Latency:
  - WAIT==0: the response is valid 1 cycle after accept (synchronous RAM read). Back-to-back accepts sustain 1 fetch/cycle when rsp_rdy stays high.
  - WAIT==N: the response is valid N+1 cycles after accept.
- FSM:
  - IDLE: on accept, go to RESP if WAIT==0, else go to WAITS with the counter loaded to WAIT-1.
  - WAITS: decrement the counter. When the counter is 0, perform the RAM read and go to RESP.
  - RESP: rsp_val=1.
    - If rsp_rdy && accept (WAIT==0 only): stay in RESP with new data.
    - If rsp_rdy && no accept: go to IDLE, rsp_val=0.
    - If !rsp_rdy: hold rsp_in/rsp_err/rsp_val unchanged.
- Stability rule: while rsp_val && !rsp_rdy, rsp_in and rsp_err must not change, even if wr_en writes the fetched address.
- Write port:
  - wr_en writes RAM[wr_addr] at the clock edge in any state except during rst.
  - A same-cycle write and read to the same index returns the OLD data (read-before-write).
  - A write never affects a response already registered.
- Reset mid-operation (WAITS or RESP): the pending response is dropped with no rsp_val pulse. A request presented in the reset cycle is not accepted.
- req_pc changes while req_rdy=0 are ignored. No request queueing beyond one outstanding fetch.

Test Plan:
- Load RAM[0]=32'h00500093 and RAM[1]=32'h00108113 via wr_en; rst; req_pc=32'h80000000 then 32'h80000004 back-to-back with rsp_rdy=1, WAIT=0 -> rsp_val on cycles 1 and 2 after the first accept, with rsp_in 00500093 then 00108113 and rsp_err=0, req_rdy high throughout.
- Stall: accept 32'h80000000 and hold rsp_rdy=0 for 3 cycles while writing RAM[0]=32'hFFFFFFFF -> rsp_in stays 00500093 and req_rdy=0. After rsp_rdy=1, the next fetch of 0x80000000 returns FFFFFFFF.
- Errors: req_pc=32'h80000002, then 32'h7FFFFFFC, then BASE+4*2**AW -> each response has rsp_err=1 and rsp_in=00000013.
- WAIT=2: accept at cycle t -> rsp_val rises at t+3, and req_rdy=0 during t+1..t+2.
- Same-cycle write/read: wr_en to idx 5 in the accept cycle of fetch 0x80000014 -> old RAM[5] returned. A refetch returns the new data.
- Reset in WAITS and in RESP with rsp_rdy=0 -> next cycle rsp_val=0, rsp_in=NOP, req_rdy=1, and no stale response appears afterwards.
